// File: rtl/ps2_key_matrix.sv
// ps2_key_matrix: PS/2 scan-code decoder keeping a held-key bitmap for the chord machine
module ps2_key_matrix #(
    parameter int NUM_KEYS       = 18,
    parameter int MAX_VOICES     = 4,
    parameter int MONO           = 0,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                            CLOCK_50,
    input  logic                            reset,
    input  logic [7:0]                      received_data,
    input  logic                            received_data_en,
    input  logic                            clear_all,
    output logic [NUM_KEYS-1:0]             key_bus,
    output logic                            key_event,
    output logic [4:0]                      event_index,
    output logic                            event_make,
    output logic [$clog2(NUM_KEYS+1)-1:0]   voice_count,
    output logic                            overflow
);
    localparam int VCW = $clog2(NUM_KEYS + 1);
    localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
    // index 0 sits in the low byte: A W S E D F T G Y H U J K O L P ; '
    localparam logic [18*8-1:0] KEY_TAB = {8'h52, 8'h4C, 8'h4D, 8'h4B, 8'h44, 8'h42,
                                           8'h3B, 8'h3C, 8'h33, 8'h35, 8'h34, 8'h2C,
                                           8'h2B, 8'h23, 8'h24, 8'h1B, 8'h1D, 8'h1C};

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]   key_bus_q, key_bus_d;
    logic                  key_event_q, key_event_d;
    logic [4:0]            event_index_q, event_index_d;
    logic                  event_make_q, event_make_d;
    logic [VCW-1:0]        voice_count_q, voice_count_d;
    logic                  overflow_q, overflow_d;
    logic                  hit;
    logic [4:0]            idx;

    // map the incoming byte onto a key index; codes beyond NUM_KEYS are not matched
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (received_data == KEY_TAB[i*8 +: 8]) begin
                hit = 1'b1;
                idx = 5'(i);
            end
        end
    end

    // prefix FSM, key bitmap update, event generation and prefix timeout
    always_comb begin
        state_d       = state_q;
        cnt_d         = (state_q == S_IDLE) ? '0 : cnt_q + CW'(1);
        key_bus_d     = key_bus_q;
        key_event_d   = 1'b0;
        event_index_d = event_index_q;
        event_make_d  = event_make_q;
        overflow_d    = overflow_q;
        if (clear_all) begin
            key_bus_d = '0;
            state_d   = S_IDLE;
            cnt_d     = '0;
        end else if (received_data_en) begin
            cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (received_data == 8'hF0) state_d = S_BRK;
                    else if (received_data == 8'hE0) state_d = S_EXT;
                    else if (received_data == 8'hAA) key_bus_d = '0;
                    else if (hit && !key_bus_q[idx]) begin
                        if (MONO != 0 || voice_count_q < VCW'(MAX_VOICES)) begin
                            if (MONO != 0) key_bus_d = '0;
                            key_bus_d[idx] = 1'b1;
                            key_event_d    = 1'b1;
                            event_index_d  = idx;
                            event_make_d   = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                S_BRK: begin
                    state_d = S_IDLE;
                    if (hit && key_bus_q[idx]) begin
                        key_bus_d[idx] = 1'b0;
                        key_event_d    = 1'b1;
                        event_index_d  = idx;
                        event_make_d   = 1'b0;
                    end
                end
                S_EXT:   state_d = (received_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
        voice_count_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) voice_count_d = voice_count_d + VCW'(key_bus_d[i]);
    end

    // state registers, all cleared by the asynchronous reset
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            key_bus_q     <= '0;
            key_event_q   <= 1'b0;
            event_index_q <= '0;
            event_make_q  <= 1'b0;
            voice_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_bus_q     <= key_bus_d;
            key_event_q   <= key_event_d;
            event_index_q <= event_index_d;
            event_make_q  <= event_make_d;
            voice_count_q <= voice_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign key_bus     = key_bus_q;
    assign key_event   = key_event_q;
    assign event_index = event_index_q;
    assign event_make  = event_make_q;
    assign voice_count = voice_count_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_ps2_key_matrix.sv
// tb_ps2_key_matrix: directed checks of the poly and mono decoders driven by one byte stream
module tb_ps2_key_matrix;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  received_data = 8'h00;
    logic        received_data_en = 1'b0;
    logic        clear_all = 1'b0;
    logic [17:0] p_key_bus, m_key_bus;
    logic        p_key_event, m_key_event;
    logic [4:0]  p_event_index, m_event_index;
    logic        p_event_make, m_event_make;
    logic [4:0]  p_voice_count, m_voice_count;
    logic        p_overflow, m_overflow;
    int          checks = 0;
    int          errors = 0;
    int          ev_cnt = 0;
    int          ev_base;

    always #5 clk = ~clk;

    ps2_key_matrix #(.NUM_KEYS(18), .MAX_VOICES(4), .MONO(0), .TIMEOUT_CYCLES(16)) u_poly (
        .CLOCK_50(clk), .reset(reset), .received_data(received_data),
        .received_data_en(received_data_en), .clear_all(clear_all),
        .key_bus(p_key_bus), .key_event(p_key_event), .event_index(p_event_index),
        .event_make(p_event_make), .voice_count(p_voice_count), .overflow(p_overflow));

    ps2_key_matrix #(.NUM_KEYS(18), .MAX_VOICES(4), .MONO(1), .TIMEOUT_CYCLES(16)) u_mono (
        .CLOCK_50(clk), .reset(reset), .received_data(received_data),
        .received_data_en(received_data_en), .clear_all(clear_all),
        .key_bus(m_key_bus), .key_event(m_key_event), .event_index(m_event_index),
        .event_make(m_event_make), .voice_count(m_voice_count), .overflow(m_overflow));

    always @(posedge clk) if (p_key_event) ev_cnt <= ev_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        received_data    = b;
        received_data_en = 1'b1;
        @(negedge clk);
        received_data_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_key_bus", p_key_bus, 0);
        chk("rst_key_event", p_key_event, 0);
        chk("rst_event_index", p_event_index, 0);
        chk("rst_event_make", p_event_make, 0);
        chk("rst_voice_count", p_voice_count, 0);
        chk("rst_overflow", p_overflow, 0);
        chk("rst_mono_key_bus", m_key_bus, 0);

        // back-to-back strobes 1C,1B,23
        ev_base = ev_cnt;
        @(negedge clk); received_data = 8'h1C; received_data_en = 1'b1;
        @(negedge clk); received_data = 8'h1B;
        @(negedge clk); received_data = 8'h23;
        @(negedge clk); received_data_en = 1'b0;
        chk("t1_key_bus", p_key_bus, 18'h15);
        chk("t1_voice_count", p_voice_count, 3);
        idle(2);
        chk("t1_events", ev_cnt - ev_base, 3);
        chk("t1_mono_key_bus", m_key_bus, 18'h10);

        // release S
        send(8'hF0);
        send(8'h1B);
        chk("t2_key_event", p_key_event, 1);
        chk("t2_event_index", p_event_index, 2);
        chk("t2_event_make", p_event_make, 0);
        chk("t2_key_bus", p_key_bus, 18'h11);
        chk("t2_voice_count", p_voice_count, 2);
        chk("t2_mono_ignore", m_key_bus, 18'h10);
        idle(1);
        chk("t2_event_one_cycle", p_key_event, 0);
        chk("t2_index_hold", p_event_index, 2);

        // voice limit
        do_reset();
        send(8'h1C); send(8'h1D); send(8'h1B); send(8'h24);
        chk("t3_no_ovf_yet", p_overflow, 0);
        send(8'h23);
        chk("t3_key_bus", p_key_bus, 18'h0F);
        chk("t3_overflow", p_overflow, 1);
        chk("t3_voice_count", p_voice_count, 4);
        chk("t3_drop_no_event", p_key_event, 0);
        chk("t3_last_index", p_event_index, 3);
        chk("t3_mono_key_bus", m_key_bus, 18'h10);
        chk("t3_mono_overflow", m_overflow, 0);
        send(8'hAA);
        chk("aa_key_bus", p_key_bus, 0);
        chk("aa_no_event", p_key_event, 0);
        chk("aa_overflow_kept", p_overflow, 1);
        chk("aa_voice_count", p_voice_count, 0);

        // clear_all beats a coincident F0
        send(8'h1D);
        chk("ca_pre", p_key_bus, 18'h02);
        @(negedge clk);
        clear_all = 1'b1; received_data = 8'hF0; received_data_en = 1'b1;
        @(negedge clk);
        clear_all = 1'b0; received_data_en = 1'b0;
        chk("ca_key_bus", p_key_bus, 0);
        chk("ca_no_event", p_key_event, 0);
        send(8'h1C);
        chk("ca_make_after", p_key_bus, 18'h01);
        chk("ca_make_flag", p_event_make, 1);

        // typematic repeat and extended prefixes
        do_reset();
        ev_base = ev_cnt;
        send(8'h1C); send(8'h1C); send(8'h1C);
        idle(2);
        chk("t4_one_event", ev_cnt - ev_base, 1);
        send(8'hE0); send(8'hF0); send(8'h1C);
        chk("t4_ext_break", p_key_bus, 18'h01);
        send(8'hE0); send(8'h1B);
        chk("t4_ext_make", p_key_bus, 18'h01);
        send(8'h1B);
        chk("t4_back_idle", p_key_bus, 18'h05);

        // mono mode
        do_reset();
        send(8'h1C); send(8'h1B);
        chk("t5_mono_key_bus", m_key_bus, 18'h04);
        send(8'h1B);
        chk("t5_mono_repeat", m_key_event, 0);
        send(8'hF0); send(8'h1C);
        chk("t5_mono_non_held", m_key_bus, 18'h04);
        send(8'hF0); send(8'h1B);
        chk("t5_mono_release", m_key_bus, 0);
        chk("t5_mono_event_make", m_event_make, 0);
        chk("t5_mono_voice_count", m_voice_count, 0);

        // prefix timeout
        do_reset();
        send(8'h1C);
        send(8'hF0);
        idle(20);
        send(8'h1B);
        chk("t6_timeout_make", p_key_bus, 18'h05);
        send(8'hF0);
        idle(5);
        send(8'h1B);
        chk("t6_short_wait_release", p_key_bus, 18'h01);

        // reset in the middle of a break sequence
        send(8'hF0);
        do_reset();
        chk("t6_rst_key_bus", p_key_bus, 0);
        chk("t6_rst_voice_count", p_voice_count, 0);
        chk("t6_rst_overflow", p_overflow, 0);
        chk("t6_rst_event_index", p_event_index, 0);
        send(8'h1C);
        chk("t6_rst_then_make", p_key_bus, 18'h01);
        chk("t6_rst_make_flag", p_event_make, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
